// File: rtl/icache_mshr_alloc.sv
// ----------------------------------------------------------------------------
// icache_mshr_alloc
//
// MSHR entry allocator for the icache miss path. It keeps a busy bitmap of
// MSHR entries and offers one free entry at a time to the request arbiter.
// Entries go back to the pool on refill completion (free) or on flush.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   alloc_vld    a free entry is being offered
//   alloc_index  index of the offered entry (stable while alloc_rdy is low)
//   alloc_rdy    consumer takes the offered entry this cycle
//   free_vld     release the entry named by free_index
//   free_index   entry to release
//   flush        release every entry
//   busy_vec     registered bitmap of allocated entries
//   busy_cnt     number of allocated entries (popcount of busy_vec)
//   full         all entries allocated
//   err_free     one-cycle pulse: a free named an entry that was not busy
// ----------------------------------------------------------------------------
module icache_mshr_alloc #(
    parameter int MSHR_ENTRY_NUM         = 8,
    parameter int MSHR_ENTRY_INDEX_WIDTH = $clog2(MSHR_ENTRY_NUM)
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              alloc_vld,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] alloc_index,
    input  logic                              alloc_rdy,
    input  logic                              free_vld,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] free_index,
    input  logic                              flush,
    output logic [MSHR_ENTRY_NUM-1:0]         busy_vec,
    output logic [MSHR_ENTRY_INDEX_WIDTH:0]   busy_cnt,
    output logic                              full,
    output logic                              err_free
);

    localparam int N  = MSHR_ENTRY_NUM;
    localparam int IW = MSHR_ENTRY_INDEX_WIDTH;

    logic [N-1:0]  busy_reg;
    logic [N-1:0]  busy_next;
    logic [N-1:0]  take_onehot;
    logic [N-1:0]  free_onehot;
    logic [N-1:0]  free_mask;
    logic          offer_vld_reg;
    logic          offer_vld_next;
    logic [IW-1:0] offer_idx_reg;
    logic [IW-1:0] offer_idx_next;
    logic          err_reg;
    logic          err_next;
    logic          transfer;
    logic          free_hit;
    logic          offer_load;
    logic [IW:0]   cnt_next;

    assign transfer = offer_vld_reg & alloc_rdy;
    // A free only counts when it names a busy entry; otherwise it is an error.
    assign free_hit = free_vld & busy_reg[free_index];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign take_onehot[gi] = transfer && (offer_idx_reg == IW'(gi));
            assign free_onehot[gi] = free_hit && (free_index == IW'(gi));
        end
    endgenerate

    // Flush wins over both take and free; a taken entry in a flush cycle is dropped.
    assign busy_next = flush ? '0 : ((busy_reg | take_onehot) & ~free_onehot);
    assign free_mask = ~busy_next;

    // Lowest-index free entry of the next busy map.
    always_comb begin
        offer_idx_next = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                offer_idx_next = IW'(i);
            end
        end
    end

    assign offer_vld_next = |free_mask;
    // A pending offer is held until taken, so alloc_index never moves under the consumer.
    assign offer_load     = !offer_vld_reg || transfer;
    assign err_next       = free_vld & ~busy_reg[free_index] & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg      <= '0;
            offer_vld_reg <= 1'b0;
            offer_idx_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            err_reg  <= err_next;
            if (offer_load) begin
                offer_vld_reg <= offer_vld_next;
                offer_idx_reg <= offer_idx_next;
            end
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + (IW + 1)'(busy_reg[i]);
        end
    end

    assign alloc_vld   = offer_vld_reg;
    assign alloc_index = offer_idx_reg;
    assign busy_vec    = busy_reg;
    assign busy_cnt    = cnt_next;
    assign full        = &busy_reg;
    assign err_free    = err_reg;

endmodule

// File: tb/tb_icache_mshr_alloc.sv
// ----------------------------------------------------------------------------
// tb_icache_mshr_alloc
//
// Self-checking bench for icache_mshr_alloc (8 entries). A hand-derived table
// walks the directed corner cases; a reference model then drives a random
// stream. In both phases the expected post-edge state is pushed to a
// scoreboard queue when inputs are driven and popped after the clock edge.
// ----------------------------------------------------------------------------
module tb_icache_mshr_alloc;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_vld;
    logic [2:0] alloc_index;
    logic       alloc_rdy;
    logic       free_vld;
    logic [2:0] free_index;
    logic       flush;
    logic [7:0] busy_vec;
    logic [3:0] busy_cnt;
    logic       full;
    logic       err_free;

    icache_mshr_alloc #(
        .MSHR_ENTRY_NUM(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_vld  (alloc_vld),
        .alloc_index(alloc_index),
        .alloc_rdy  (alloc_rdy),
        .free_vld   (free_vld),
        .free_index (free_index),
        .flush      (flush),
        .busy_vec   (busy_vec),
        .busy_cnt   (busy_cnt),
        .full       (full),
        .err_free   (err_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       fv;
        logic [2:0] fi;
        logic       fl;
        logic       e_vld;
        logic [2:0] e_idx;
        logic [7:0] e_busy;
        logic       e_err;
    } vec_t;

    typedef struct {
        logic       vld;
        logic       chk_idx;
        logic [2:0] idx;
        logic [7:0] busy;
        logic       err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // reference model state for the random phase
    logic [7:0] m_busy;
    logic       m_vld;
    logic [2:0] m_idx;
    logic       m_err;

    task automatic addv(input logic r, input logic rdy, input logic fv, input logic [2:0] fi,
                        input logic fl, input logic ev, input logic [2:0] ei,
                        input logic [7:0] eb, input logic ee);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.fv = fv; v.fi = fi; v.fl = fl;
        v.e_vld = ev; v.e_idx = ei; v.e_busy = eb; v.e_err = ee;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, push the expectation, clock, pop and compare.
    task automatic apply(input logic r, input logic rdy, input logic fv, input logic [2:0] fi,
                         input logic fl, input exp_t e, input string tag);
        exp_t got_e;
        rst = r; alloc_rdy = rdy; free_vld = fv; free_index = fi; flush = fl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got_e = sb.pop_front();
            check({tag, ".alloc_vld"}, int'(alloc_vld), int'(got_e.vld));
            if (got_e.chk_idx) check({tag, ".alloc_index"}, int'(alloc_index), int'(got_e.idx));
            check({tag, ".busy_vec"}, int'(busy_vec), int'(got_e.busy));
            check({tag, ".busy_cnt"}, int'(busy_cnt), $countones(got_e.busy));
            check({tag, ".full"}, int'(full), int'(got_e.busy == 8'hFF));
            check({tag, ".err_free"}, int'(err_free), int'(got_e.err));
            if (alloc_vld && busy_vec[alloc_index]) begin
                n_vec++; n_miss++;
                $display("FAIL %s.offer_busy: got idx %0d busy_vec %0h expected idle entry", tag, alloc_index, busy_vec);
            end
        end
    endtask

    // Model step: computes post-edge state from current model state and inputs.
    task automatic model_step(input logic r, input logic rdy, input logic fv, input logic [2:0] fi,
                              input logic fl);
        logic [7:0] nb;
        logic       xfer;
        xfer = m_vld && rdy;
        if (r) begin
            m_busy = '0; m_vld = 1'b0; m_idx = '0; m_err = 1'b0;
        end else begin
            nb = m_busy;
            if (xfer) nb[m_idx] = 1'b1;
            if (fv && m_busy[fi]) nb[fi] = 1'b0;
            if (fl) nb = '0;
            m_err = fv && !m_busy[fi] && !fl;
            if (!m_vld || xfer) begin
                m_vld = (nb != 8'hFF);
                m_idx = '0;
                for (int k = 7; k >= 0; k--) if (!nb[k]) m_idx = 3'(k);
            end
            m_busy = nb;
        end
    endtask

    initial begin
        exp_t e;
        // rst rdy fv fi fl | vld idx busy err
        addv(1,0,0,0,0, 0,0,8'h00,0);                 // reset
        for (int i = 0; i < 5; i++) addv(0,0,0,0,0, 1,0,8'h00,0); // offer 0 held
        for (int i = 0; i < 7; i++)                   // back-to-back grants 0..6
            addv(0,1,0,0,0, 1,3'(i+1),8'((16'h1 << (i+1)) - 1),0);
        addv(0,1,0,0,0, 0,0,8'hFF,0);                 // grant 7 -> full
        addv(0,0,1,5,0, 1,5,8'hDF,0);                 // free 5 while full
        addv(0,1,0,0,0, 0,0,8'hFF,0);                 // take 5 -> full again
        addv(0,0,0,0,1, 1,0,8'h00,0);                 // flush, no offer pending
        addv(0,1,0,0,0, 1,1,8'h01,0);
        addv(0,1,0,0,0, 1,2,8'h03,0);
        addv(0,1,0,0,0, 1,3,8'h07,0);
        addv(0,1,0,0,0, 1,4,8'h0F,0);                 // 0-3 busy, offer 4
        addv(0,0,1,1,0, 1,4,8'h0D,0);                 // free 1, offer stays 4
        addv(0,1,0,0,0, 1,1,8'h1D,0);                 // take 4, next offer 1
        addv(0,0,1,6,0, 1,1,8'h1D,1);                 // free idle 6 -> err
        addv(0,0,0,0,0, 1,1,8'h1D,0);                 // err is one cycle
        addv(0,1,1,2,0, 1,2,8'h1B,0);                 // take 1 + free 2
        addv(0,1,1,0,0, 1,0,8'h1E,0);                 // take 2 + free 0
        addv(0,0,1,0,0, 1,0,8'h1E,1);                 // free the offered idle entry
        addv(0,0,0,0,0, 1,0,8'h1E,0);
        addv(0,1,0,0,0, 1,5,8'h1F,0);
        addv(0,1,0,0,0, 1,6,8'h3F,0);                 // 0-5 busy, offer 6
        addv(0,1,0,0,1, 1,0,8'h00,0);                 // flush + transfer of 6
        addv(0,1,0,0,0, 1,1,8'h01,0);
        addv(0,1,0,0,0, 1,2,8'h03,0);
        addv(0,0,0,0,1, 1,2,8'h00,0);                 // flush with held offer 2
        addv(0,0,1,7,1, 1,2,8'h00,0);                 // bad free under flush: no err
        addv(0,1,0,0,0, 1,0,8'h04,0);
        addv(1,1,1,3,0, 0,0,8'h00,0);                 // reset mid-stream
        addv(0,0,0,0,0, 1,0,8'h00,0);

        for (int i = 0; i < tbl.size(); i++) begin
            e.vld = tbl[i].e_vld; e.chk_idx = tbl[i].e_vld || tbl[i].rst;
            e.idx = tbl[i].e_idx; e.busy = tbl[i].e_busy; e.err = tbl[i].e_err;
            apply(tbl[i].rst, tbl[i].rdy, tbl[i].fv, tbl[i].fi, tbl[i].fl, e, $sformatf("vec%0d", i));
            $display("vec%0d rst=%0b rdy=%0b free=%0b/%0d flush=%0b -> vld=%0b idx=%0d busy=%02h err=%0b",
                     i, tbl[i].rst, tbl[i].rdy, tbl[i].fv, tbl[i].fi, tbl[i].fl,
                     alloc_vld, alloc_index, busy_vec, err_free);
        end

        // Random phase driven from the reference model.
        model_step(1, 0, 0, 0, 0);
        e.vld = m_vld; e.chk_idx = 1'b1; e.idx = m_idx; e.busy = m_busy; e.err = m_err;
        apply(1, 0, 0, 0, 0, e, "rnd_rst");
        for (int i = 0; i < 400; i++) begin
            logic r, rdy, fv, fl;
            logic [2:0] fi;
            logic       took;
            r   = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            fv  = ($urandom_range(0, 9) < 4);
            fi  = 3'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 39) == 0);
            took = m_vld && rdy && !r;
            model_step(r, rdy, fv, fi, fl);
            e.vld = m_vld; e.chk_idx = m_vld || r; e.idx = m_idx; e.busy = m_busy; e.err = m_err;
            apply(r, rdy, fv, fi, fl, e, $sformatf("rnd%0d", i));
            if (took) $display("rnd%0d grant, busy=%02h next_offer=%0b/%0d", i, busy_vec, alloc_vld, alloc_index);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
